// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control sequencer for the RV32I datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath enables, counts retired instructions, handles halt and traps.
// Optional feature macro: MC_CTRL_MEM_WAIT_EN (MEM stalls until mem_ready).
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       instr_opcode,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             ir_en,
    output logic             rf_wr_en,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src_imm,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t           state_q;
    logic [6:0]       op_q;
    logic [CNT_W-1:0] retired_q;
    logic             illegal_q;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL);
    endfunction

`ifdef MC_CTRL_MEM_WAIT_EN
    logic mem_done;
    assign mem_done = mem_ready;
`else
    // MEM is always a single cycle; mem_ready has no effect in this build.
    logic mem_done;
    logic mem_ready_unused;
    assign mem_done         = 1'b1;
    assign mem_ready_unused = mem_ready;
`endif

    // State register, latched opcode, trap flag and retired counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (pc_en) retired_q <= retired_q + CNT_W'(1);
            case (state_q)
                S_FETCH:  state_q <= halt_req ? S_HALT : S_DECODE;
                S_DECODE: begin
                    op_q <= instr_opcode;
                    if (is_legal(instr_opcode)) begin
                        state_q <= S_EXEC;
                    end else begin
                        state_q   <= S_TRAP;
                        illegal_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (op_q == OP_BRANCH)
                        state_q <= S_FETCH;
                    else if (op_q == OP_LOAD || op_q == OP_STORE)
                        state_q <= S_MEM;
                    else
                        state_q <= S_WB;
                end
                S_MEM: begin
                    if (mem_done) state_q <= (op_q == OP_LOAD) ? S_WB : S_FETCH;
                end
                S_WB:   state_q <= S_FETCH;
                S_HALT: if (!halt_req) state_q <= S_FETCH;
                S_TRAP: illegal_q <= 1'b1;
                default: begin
                    // Unused encoding: treat as a trap.
                    state_q   <= S_TRAP;
                    illegal_q <= 1'b1;
                end
            endcase
        end
    end

    // Enables decoded from the registered state and latched opcode; all
    // forced low while reset is held.
    always_comb begin
        pc_en       = 1'b0;
        pc_sel      = 1'b0;
        ir_en       = 1'b0;
        rf_wr_en    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        alu_src_imm = 1'b0;
        wb_sel      = 2'd0;
        if (!rst) begin
            case (state_q)
                S_FETCH: ir_en = !halt_req;
                S_EXEC: begin
                    alu_src_imm = (op_q == OP_I) || (op_q == OP_LOAD) || (op_q == OP_STORE);
                    if (op_q == OP_BRANCH) begin
                        pc_en  = 1'b1;
                        pc_sel = branch_taken;
                    end
                end
                S_MEM: begin
                    alu_src_imm = 1'b1;
                    if (op_q == OP_LOAD) begin
                        mem_read = 1'b1;
                    end else begin
                        mem_write = 1'b1;
                        pc_en     = mem_done;
                    end
                end
                S_WB: begin
                    rf_wr_en = 1'b1;
                    pc_en    = 1'b1;
                    pc_sel   = (op_q == OP_JAL);
                    wb_sel   = (op_q == OP_LOAD) ? 2'd1 : (op_q == OP_JAL) ? 2'd2 : 2'd0;
                end
                default: ;
            endcase
        end
    end

    // Status outputs; state stays visible during reset for debug.
    always_comb begin
        state   = state_q;
        illegal = illegal_q & ~rst;
        retired = rst ? '0 : retired_q;
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed per-cycle bench for mc_ctrl_fsm with an
// expectation queue; covers every opcode class, halt, trap, reset and wrap.
module tb_mc_ctrl_fsm;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    // Output vector bit positions: {pc_en,pc_sel,ir_en,rf_wr_en,mem_read,
    // mem_write,alu_src_imm,wb_sel[1:0],illegal}
    localparam logic [9:0] PCE = 10'h200, PCS = 10'h100, IRE = 10'h080;
    localparam logic [9:0] RFW = 10'h040, MRD = 10'h020, MWR = 10'h010;
    localparam logic [9:0] ASI = 10'h008, WB2 = 10'h004, WB1 = 10'h002;
    localparam logic [9:0] ILL = 10'h001, NONE = 10'h000;

    typedef struct packed {
        logic [2:0]  st;
        logic [9:0]  o;
        logic [31:0] ret;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, branch_taken, halt_req, mem_ready;
    logic [6:0]  instr_opcode;
    logic        pc_en, pc_sel, ir_en, rf_wr_en, mem_read, mem_write, alu_src_imm, illegal;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
    logic [31:0] retired;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    mc_ctrl_fsm #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .instr_opcode(instr_opcode), .branch_taken(branch_taken),
        .halt_req(halt_req), .mem_ready(mem_ready), .pc_en(pc_en), .pc_sel(pc_sel),
        .ir_en(ir_en), .rf_wr_en(rf_wr_en), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src_imm(alu_src_imm), .wb_sel(wb_sel), .state(state), .illegal(illegal),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // One clock cycle: queue the expectation with the current inputs, check
    // at the falling edge, then return just after the next rising edge.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [9:0] o,
                       input logic [31:0] ret);
        exp_t e;
        logic [9:0] got;
        sb.push_back('{st: st, o: o, ret: ret});
        @(negedge clk);
        got = {pc_en, pc_sel, ir_en, rf_wr_en, mem_read, mem_write, alu_src_imm, wb_sel, illegal};
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            checks++;
            assert (state === e.st) else begin
                errors++;
                $error("FAIL %s state got %0d exp %0d", tag, state, e.st);
            end
            checks++;
            assert (got === e.o) else begin
                errors++;
                $error("FAIL %s outs got %b exp %b", tag, got, e.o);
            end
            checks++;
            assert (retired === e.ret) else begin
                errors++;
                $error("FAIL %s retired got %0h exp %0h", tag, retired, e.ret);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; halt_req = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0;
        instr_opcode = OP_R;
        @(posedge clk);
        #1;
        cyc("rst_a", 3'd0, NONE, 0);
        cyc("rst_b", 3'd0, NONE, 0);

        // R-type: 0,1,2,4 then FETCH
        rst = 1'b0;
        cyc("r_fetch", 3'd0, IRE, 0);
        cyc("r_dec",   3'd1, NONE, 0);
        cyc("r_exec",  3'd2, NONE, 0);
        cyc("r_wb",    3'd4, RFW | PCE, 0);

        // LOAD: 5-cycle loop
        instr_opcode = OP_LOAD;
        cyc("ld_fetch", 3'd0, IRE, 1);
        cyc("ld_dec",   3'd1, NONE, 1);
        cyc("ld_exec",  3'd2, ASI, 1);
        cyc("ld_mem",   3'd3, MRD | ASI, 1);
        cyc("ld_wb",    3'd4, RFW | PCE | WB1, 1);

        // BRANCH taken, then not taken
        instr_opcode = OP_BRANCH;
        branch_taken = 1'b1;
        cyc("bt_fetch", 3'd0, IRE, 2);
        cyc("bt_dec",   3'd1, NONE, 2);
        cyc("bt_exec",  3'd2, PCE | PCS, 2);
        branch_taken = 1'b0;
        cyc("bn_fetch", 3'd0, IRE, 3);
        cyc("bn_dec",   3'd1, NONE, 3);
        cyc("bn_exec",  3'd2, PCE, 3);

        // I-type
        instr_opcode = OP_I;
        cyc("i_fetch", 3'd0, IRE, 4);
        cyc("i_dec",   3'd1, NONE, 4);
        cyc("i_exec",  3'd2, ASI, 4);
        cyc("i_wb",    3'd4, RFW | PCE, 4);

        // JAL
        instr_opcode = OP_JAL;
        cyc("j_fetch", 3'd0, IRE, 5);
        cyc("j_dec",   3'd1, NONE, 5);
        cyc("j_exec",  3'd2, NONE, 5);
        cyc("j_wb",    3'd4, RFW | PCE | PCS | WB2, 5);

        // STORE with halt raised in DECODE: store completes, then HALT
        instr_opcode = OP_STORE;
        mem_ready = 1'b1;
        cyc("sh_fetch", 3'd0, IRE, 6);
        halt_req = 1'b1;
        cyc("sh_dec",   3'd1, NONE, 6);
        cyc("sh_exec",  3'd2, ASI, 6);
        cyc("sh_mem",   3'd3, MWR | ASI | PCE, 6);
        cyc("sh_fetch_halt", 3'd0, NONE, 7);
        cyc("halt_a",   3'd5, NONE, 7);
        cyc("halt_b",   3'd5, NONE, 7);
        halt_req = 1'b0;
        cyc("halt_rel", 3'd5, NONE, 7);

        // STORE with mem_ready low
        mem_ready = 1'b0;
        cyc("sw_fetch", 3'd0, IRE, 7);
        cyc("sw_dec",   3'd1, NONE, 7);
        cyc("sw_exec",  3'd2, ASI, 7);
`ifdef MC_CTRL_MEM_WAIT_EN
        cyc("sw_wait1", 3'd3, MWR | ASI, 7);
        cyc("sw_wait2", 3'd3, MWR | ASI, 7);
        cyc("sw_wait3", 3'd3, MWR | ASI, 7);
        mem_ready = 1'b1;
        cyc("sw_ready", 3'd3, MWR | ASI | PCE, 7);
        mem_ready = 1'b0;
`else
        cyc("sw_mem",   3'd3, MWR | ASI | PCE, 7);
`endif

        // Counter wrap: preload all-ones, retire one R-type
        instr_opcode = OP_R;
        cyc("wr_fetch", 3'd0, IRE, 8);
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        cyc("wr_dec",   3'd1, NONE, 32'hFFFF_FFFF);
        cyc("wr_exec",  3'd2, NONE, 32'hFFFF_FFFF);
        cyc("wr_wb",    3'd4, RFW | PCE, 32'hFFFF_FFFF);

        // Illegal opcode: TRAP is sticky, ignores halt, cleared by reset
        instr_opcode = OP_BAD;
        cyc("wr_wrap",  3'd0, IRE, 0);
        cyc("ill_dec",  3'd1, NONE, 0);
        for (int i = 0; i < 10; i++) begin
            halt_req = (i >= 5);
            cyc("trap_hold", 3'd6, ILL, 0);
        end
        halt_req = 1'b0;
        rst = 1'b1;
        cyc("trap_rst", 3'd6, NONE, 0);
        rst = 1'b0;
        instr_opcode = OP_R;
        cyc("trap_clr", 3'd0, IRE, 0);

        // Reset in EXEC discards the instruction
        cyc("mr_dec",   3'd1, NONE, 0);
        rst = 1'b1;
        cyc("mr_exec",  3'd2, NONE, 0);
        rst = 1'b0;
        cyc("mr_after", 3'd0, IRE, 0);

        // Reset and halt together: reset wins, then halt honoured in FETCH
        rst = 1'b1;
        halt_req = 1'b1;
        cyc("rh_both",  3'd1, NONE, 0);
        rst = 1'b0;
        cyc("rh_fetch", 3'd0, NONE, 0);
        cyc("rh_halt",  3'd5, NONE, 0);
        halt_req = 1'b0;
        cyc("rh_rel",   3'd5, NONE, 0);
        cyc("rh_back",  3'd0, IRE, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
